// File: rtl/trigger_unit.sv
// Trigger unit: prescaled probe sampling, edge trigger detection and arm/capture sequencing.
// Optional feature macro: TRIG_TIMEOUT_EN forces a trigger after TIMEOUT_SAMPLES idle ARMED samples.
module trigger_unit #(
    parameter int CHANNELS        = 16,
    parameter int POST_TRIG_DEPTH = 1024,
    parameter int TIMEOUT_SAMPLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] data_in,
    input  logic [15:0]         prescaling_factor,
    input  logic [1:0]          trigger_kind [CHANNELS],
    input  logic                arm,
    input  logic                abort,
    output logic                sample_valid,
    output logic [CHANNELS-1:0] sample_data,
    output logic                triggered,
    output logic [1:0]          state,
    output logic                timed_out
);
    localparam int PW = $clog2(POST_TRIG_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    if (POST_TRIG_DEPTH < 1 || TIMEOUT_SAMPLES < 1) begin : g_param_check
        $error("trigger_unit: POST_TRIG_DEPTH and TIMEOUT_SAMPLES must be at least 1");
    end

    state_t              state_q;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [15:0]         pre_count;
    logic [15:0]         pre_n;
    logic [15:0]         n_eff;
    logic [PW-1:0]       post_count;
    logic                prev_valid;
    logic                running;
    logic                tick;
    logic                free_run;
    logic                edge_hit;
    logic                trig_hit;
    logic                force_trig;

    assign state   = state_q;
    assign n_eff   = (prescaling_factor == 16'd0) ? 16'd1 : prescaling_factor;
    assign running = (state_q == ARMED) || (state_q == CAPTURE);
    assign tick    = running && (pre_count == pre_n - 16'd1);

    // sample_data doubles as the previous-sample register for edge detection
    always_comb begin
        free_run = 1'b1;
        edge_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (trigger_kind[i] != 2'b00)
                free_run = 1'b0;
            if (prev_valid && trigger_kind[i][0] && !sample_data[i] && sync2[i])
                edge_hit = 1'b1;
            if (prev_valid && trigger_kind[i][1] && sample_data[i] && !sync2[i])
                edge_hit = 1'b1;
        end
    end

    assign trig_hit = free_run || edge_hit;

`ifdef TRIG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);

    logic [TW-1:0] to_count;
    logic          to_flag;

    assign force_trig = (to_count == TW'(TIMEOUT_SAMPLES));
    assign timed_out  = to_flag;

    // Counts untriggered ARMED samples; a real trigger on the forcing sample leaves the flag clear
    always_ff @(posedge clk) begin
        if (rst) begin
            to_count <= '0;
            to_flag  <= 1'b0;
        end else if (!abort && arm && (state_q == IDLE || state_q == DONE)) begin
            to_count <= '0;
            to_flag  <= 1'b0;
        end else if (!abort && tick && state_q == ARMED && !trig_hit) begin
            if (force_trig)
                to_flag <= 1'b1;
            else
                to_count <= to_count + TW'(1);
        end
    end
`else
    assign force_trig = 1'b0;
    assign timed_out  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            state_q      <= IDLE;
            pre_count    <= '0;
            pre_n        <= 16'd1;
            post_count   <= '0;
            prev_valid   <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            triggered    <= 1'b0;
        end else begin
            sync1        <= data_in;
            sync2        <= sync1;
            sample_valid <= 1'b0;
            triggered    <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (arm) begin
                            state_q    <= ARMED;
                            pre_count  <= '0;
                            pre_n      <= n_eff;
                            prev_valid <= 1'b0;
                        end
                    end
                    ARMED, CAPTURE: begin
                        // Period is re-latched at every wrap so changes apply from the next period
                        if (tick) begin
                            pre_count    <= '0;
                            pre_n        <= n_eff;
                            sample_valid <= 1'b1;
                            sample_data  <= sync2;
                            if (state_q == ARMED) begin
                                prev_valid <= 1'b1;
                                if (trig_hit || force_trig) begin
                                    triggered  <= 1'b1;
                                    post_count <= PW'(1);
                                    state_q    <= (POST_TRIG_DEPTH == 1) ? DONE : CAPTURE;
                                end
                            end else begin
                                post_count <= post_count + PW'(1);
                                if (post_count + PW'(1) == PW'(POST_TRIG_DEPTH))
                                    state_q <= DONE;
                            end
                        end else begin
                            pre_count <= pre_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_unit.sv
// Bench for trigger_unit: directed scenarios plus a randomized phase, checked every cycle
// against a sample-schedule reference model.
module tb_trigger_unit;
    localparam int CH         = 16;
    localparam int DEPTH      = 128;
    localparam int TO_SAMPLES = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] data_in;
    logic [15:0]   pf;
    logic [1:0]    tk [CH];
    logic          arm;
    logic          abort;
    logic          sample_valid;
    logic [CH-1:0] sample_data;
    logic          triggered;
    logic [1:0]    state;
    logic          timed_out;

    always #5 clk = ~clk;

    trigger_unit #(
        .CHANNELS        (CH),
        .POST_TRIG_DEPTH (DEPTH),
        .TIMEOUT_SAMPLES (TO_SAMPLES)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .prescaling_factor (pf),
        .trigger_kind      (tk),
        .arm               (arm),
        .abort             (abort),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .triggered         (triggered),
        .state             (state),
        .timed_out         (timed_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capture, 3 done; samples scheduled by absolute cycle
    int            cyc = 0;
    int            m_mode = 0;
    int            m_next_tick = 0;
    int            m_post = 0;
    int            m_armed_seen = 0;
    bit            m_prev_valid = 0;
    logic [CH-1:0] hist [$];
    logic          exp_valid = 0;
    logic          exp_trig = 0;
    logic          exp_to = 0;
    logic [CH-1:0] exp_data = '0;
    int            strobes = 0;
    int            trigs = 0;

    function automatic int eff_n(input logic [15:0] p);
        return (p == 16'd0) ? 1 : int'(p);
    endfunction

    function automatic bit all_none();
        for (int ch = 0; ch < CH; ch++)
            if (tk[ch] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit edge_match(input logic [CH-1:0] prev, input logic [CH-1:0] cur);
        bit up;
        bit down;
        for (int ch = 0; ch < CH; ch++) begin
            up   = !prev[ch] && cur[ch];
            down = prev[ch] && !cur[ch];
            case (tk[ch])
                2'd1: if (up) return 1'b1;
                2'd2: if (down) return 1'b1;
                2'd3: if (up || down) return 1'b1;
                default: ;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic modelStep();
        logic [CH-1:0] cur;
        bit hit;
        bit forced;
        exp_valid = 1'b0;
        exp_trig  = 1'b0;
        if (rst) begin
            m_mode       = 0;
            exp_data     = '0;
            exp_to       = 1'b0;
            m_prev_valid = 1'b0;
            hist         = '{CH'(0), CH'(0)};
        end else begin
            hist.push_back(data_in);
            if (hist.size() > 3) void'(hist.pop_front());
            cur = hist[0];
            if (abort) begin
                m_mode = 0;
            end else if (m_mode == 0 || m_mode == 3) begin
                if (arm) begin
                    m_mode       = 1;
                    m_next_tick  = cyc + eff_n(pf);
                    m_prev_valid = 1'b0;
                    m_armed_seen = 0;
                    exp_to       = 1'b0;
                end
            end else if (cyc == m_next_tick) begin
                m_next_tick = cyc + eff_n(pf);
                exp_valid   = 1'b1;
                if (m_mode == 1) begin
                    hit    = all_none() || (m_prev_valid && edge_match(exp_data, cur));
                    forced = 1'b0;
`ifdef TRIG_TIMEOUT_EN
                    forced = !hit && (m_armed_seen == TO_SAMPLES);
`endif
                    m_armed_seen++;
                    m_prev_valid = 1'b1;
                    if (hit || forced) begin
                        exp_trig = 1'b1;
                        exp_to   = exp_to | forced;
                        m_post   = 1;
                        m_mode   = (DEPTH == 1) ? 3 : 2;
                    end
                end else begin
                    m_post++;
                    if (m_post == DEPTH) m_mode = 3;
                end
                exp_data = cur;
            end
        end
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        check("state", 32'(state), 32'(m_mode));
        check("sample_valid", 32'(sample_valid), 32'(exp_valid));
        check("triggered", 32'(triggered), 32'(exp_trig));
        check("sample_data", 32'(sample_data), 32'(exp_data));
        check("timed_out", 32'(timed_out), 32'(exp_to));
        if (sample_valid === 1'b1) strobes++;
        if (triggered === 1'b1) trigs++;
    endtask

    // Inputs for the current cycle are already driven; advance one cycle and compare
    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) data_in = CH'($urandom);
            applyStimulus();
            arm   = 1'b0;
            abort = 1'b0;
        end
    endtask

    task automatic setKinds(input int ch_a, input logic [1:0] k_a, input int ch_b, input logic [1:0] k_b);
        for (int ch = 0; ch < CH; ch++) tk[ch] = 2'b00;
        if (ch_a >= 0) tk[ch_a] = k_a;
        if (ch_b >= 0) tk[ch_b] = k_b;
    endtask

    initial begin
        bit found;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; pf = 16'd1; data_in = '0;
        setKinds(-1, 2'b00, -1, 2'b00);
        cycles(3, 1'b0);
        rst = 1'b0;
        cycles(2, 1'b0);

        $display("[TB] free-run capture, prescale 4");
        pf = 16'd4; strobes = 0; trigs = 0;
        arm = 1'b1;
        cycles(560, 1'b1);
        check("freerun_strobes", 32'(strobes), 32'(DEPTH));
        check("freerun_trigs", 32'(trigs), 32'd1);
        check("freerun_done", 32'(state), 32'd3);

        $display("[TB] prescale 0 and 1");
        for (int p = 0; p < 2; p++) begin
            pf = 16'(p); strobes = 0;
            arm = 1'b1;
            cycles(20, 1'b1);
            check("every_cycle_strobes", 32'(strobes), 32'd19);
            abort = 1'b1;
            cycles(2, 1'b1);
        end

        $display("[TB] ch3 rising trigger");
        setKinds(3, 2'b01, -1, 2'b00);
        pf = 16'd3; data_in = 16'h0008;
        cycles(5, 1'b0);
        arm = 1'b1;
        cycles(6, 1'b0);
        data_in = 16'h0000; trigs = 0;
        cycles(30, 1'b0);
        check("ch3_no_fall_trig", 32'(trigs), 32'd0);
        data_in = 16'h0008;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycles(1, 1'b0);
            if (triggered === 1'b1) found = 1'b1;
        end
        check("ch3_rise_trig", 32'(found), 32'd1);

        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (m_mode == 2 && m_post == 100) found = 1'b1;
            else cycles(1, 1'b0);
        end
        check("reach_post100", 32'(found), 32'd1);
        abort = 1'b1;
        cycles(1, 1'b0);
        check("abort_idle", 32'(state), 32'd0);
        strobes = 0;
        cycles(20, 1'b0);
        check("post_abort_strobes", 32'(strobes), 32'd0);

        $display("[TB] pre-arm edge and simultaneous edges");
        setKinds(0, 2'b10, 5, 2'b11);
        pf = 16'd2; data_in = 16'h0021;
        cycles(10, 1'b0);
        trigs = 0;
        arm = 1'b1;
        cycles(12, 1'b0);
        check("prearm_no_trig", 32'(trigs), 32'd0);
        abort = 1'b1;
        data_in = 16'h0001;
        cycles(10, 1'b0);
        arm = 1'b1;
        cycles(12, 1'b0);
        data_in = 16'h0020;
        cycles(12, 1'b0);
        check("dual_edge_single_trig", 32'(trigs), 32'd1);

        $display("[TB] arm plus abort from DONE, then mid-run reset");
        setKinds(-1, 2'b00, -1, 2'b00);
        pf = 16'd1;
        arm = 1'b1;
        cycles(140, 1'b1);
        check("done_reached", 32'(state), 32'd3);
        arm = 1'b1; abort = 1'b1;
        cycles(2, 1'b1);
        check("arm_abort_idle", 32'(state), 32'd0);
        arm = 1'b1;
        cycles(10, 1'b1);
        rst = 1'b1;
        cycles(1, 1'b1);
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        cycles(3, 1'b1);

`ifdef TRIG_TIMEOUT_EN
        $display("[TB] timeout forcing");
        setKinds(3, 2'b01, -1, 2'b00);
        data_in = '0; trigs = 0;
        arm = 1'b1;
        cycles(15, 1'b0);
        check("timeout_trig", 32'(trigs), 32'd1);
        check("timeout_flag", 32'(timed_out), 32'd1);
        abort = 1'b1;
        cycles(1, 1'b0);
        arm = 1'b1;
        cycles(2, 1'b0);
        check("timeout_cleared", 32'(timed_out), 32'd0);
        abort = 1'b1;
        cycles(1, 1'b0);
`endif

        $display("[TB] randomized phase");
        for (int i = 0; i < 1500; i++) begin
            data_in = data_in ^ CH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) pf = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 31) == 0)
                for (int ch = 0; ch < CH; ch++)
                    tk[ch] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            arm   = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            applyStimulus();
        end
        rst = 1'b0; arm = 1'b0; abort = 1'b0;
        cycles(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trigger_unit.md
Name: trigger_unit

Overview:
- Downstream consumer of the front-panel controller's PRESCALING_FACTOR and TRIGGER_KIND outputs.
- Generates the sample strobe from the prescaling factor and samples the 16 probe inputs.
- Detects the per-channel trigger condition and runs an arm/capture state machine that counts a fixed number of post-trigger samples.
- Its sample_valid/sample_data output feeds the capture memory.

Parameters:
- CHANNELS, 16: number of probe channels; width of data_in and sample_data; length of trigger_kind.
- POST_TRIG_DEPTH, 1024: samples emitted in CAPTURE, trigger sample included; must be at least 1.
- TIMEOUT_SAMPLES, 4096: ARMED-state sample count before forced trigger; used only with TRIG_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  CHANNELS  raw asynchronous probe inputs.
- prescaling_factor  input  16  unsigned; one sample every N clk cycles; 0 is treated as 1.
- trigger_kind  input  2 x CHANNELS (unpacked array)  per channel: 00 none, 01 rising, 10 falling, 11 both.
- arm  input  1  one-cycle start request.
- abort  input  1  one-cycle cancel request.
- sample_valid  output  1  one-cycle strobe; sample_data is valid this cycle.
- sample_data  output  CHANNELS  captured sample.
- triggered  output  1  one-cycle pulse, coincident with sample_valid of the trigger sample.
- state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
- timed_out  output  1  sticky; set when trigger was forced by timeout (macro only, else tied 0).

Behaviour:
- Reset values: state=IDLE, sample_valid=0, sample_data=0, triggered=0, timed_out=0, prescaler count=0, prev_valid=0.
- Input path: data_in passes through a 2-flop synchronizer; samples are taken from the synchronized value.
- Prescaler:
  - Counter runs only in ARMED and CAPTURE; tick when count == N-1, then count wraps to 0.
  - N = prescaling_factor, with 0 mapped to 1; N=1 gives a tick every cycle.
  - N is latched at arm and at every wrap, so a mid-period change takes effect at the next period.
  - Counter is cleared on arm.
- Sampling latency: tick in cycle k -> sample_data loaded and sample_valid=1 in cycle k+1.
- Edge detection:
  - Compares the current sample against the previous sample register.
  - Rising = prev 0, cur 1. Falling = prev 1, cur 0. Both = either edge.
  - Channel matches per its trigger_kind; trigger condition = OR of all channel matches.
  - No edge match is possible until prev_valid=1; prev_valid is cleared on arm and set after the first ARMED sample.
- Free-run: if all trigger_kind are 00, the first sample in ARMED is the trigger sample.
- trigger_kind is sampled live (not latched) and evaluated on each sample.
- States:
  - IDLE: no samples. arm -> ARMED.
  - ARMED: samples emitted with sample_valid. First sample meeting the trigger condition -> triggered=1 on that cycle, post counter=1, -> CAPTURE. If POST_TRIG_DEPTH==1, -> DONE directly.
  - CAPTURE: each sample increments the post counter; the sample that makes the count equal POST_TRIG_DEPTH is emitted, then -> DONE on the same edge.
  - DONE: no samples; outputs hold last sample_data. arm -> ARMED.
- abort in any state -> IDLE next cycle; any sample pending in that cycle is suppressed.
- Simultaneous arm and abort: abort wins.
- arm while in ARMED or CAPTURE: ignored.
- Post counter width is clog2(POST_TRIG_DEPTH+1); no wrap is possible.
- rst mid-operation: all registers return to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: TRIG_TIMEOUT_EN.
- Defined: ARMED counts samples. When TIMEOUT_SAMPLES samples have elapsed without a trigger, the next sample is forced as the trigger sample (triggered=1, -> CAPTURE) and timed_out is set. timed_out clears on arm or rst. A real trigger on the same sample takes priority and leaves timed_out=0.
- Undefined: no timeout counter; ARMED waits indefinitely; timed_out is tied 0.

Test Plan:
- prescaling_factor=4, trigger_kind all 00, arm -> sample_valid every 4 cycles. First sample has triggered=1. Exactly POST_TRIG_DEPTH valid strobes, then state=DONE.
- prescaling_factor=0 vs 1 -> identical traces; sample_valid asserted every cycle in ARMED/CAPTURE.
- ch3=01, others 00; data_in[3] held 0 for 10 samples, then 1 -> triggered on the first sample with bit3=1 (about 3 cycles after the input change, plus alignment to the prescale period). A falling edge on ch3 does not trigger.
- ch0=10, data_in[0]=1 already high at arm then falls; ch5=11 with a rising edge on the same sample -> single triggered pulse. A pre-arm edge does not trigger (prev_valid rule).
- abort during CAPTURE at count 100 -> state=IDLE next cycle, no further sample_valid. arm+abort in the same cycle from DONE -> IDLE.
- TRIG_TIMEOUT_EN, TIMEOUT_SAMPLES=8, no edges -> 9th ARMED sample has triggered=1 and timed_out=1. Re-arm clears timed_out.
